riscv_wb: RTL
=============

# riscv_wb

Write-back stage of the RISC-V core pipeline. It consumes the MEM-stage register outputs (PC, instruction, bubble, exception, ALU result, data-memory address) and completes data-memory transactions. It holds the pipeline with `wb_stall` until the data-memory response arrives, then aligns and extends load data. It produces the registered register-file write port and the committed exception vector that flushes the earlier stages.

## Interface
Parameters:
- `XLEN`, 32, datapath width (32 or 64).
- `PC_INIT`, 'h200, reset value of `wb_pc`.

Ports:
- `clk`  in  1  single clock; all state is updated on its rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `mem_pc`  in  XLEN  PC of the instruction in MEM.
- `mem_instr`  in  ILEN  instruction in MEM.
- `mem_bubble`  in  1  MEM slot is empty.
- `mem_exception`  in  EXCEPTION_SIZE  exceptions raised upstream.
- `mem_pc_badaddr`  in  XLEN  bad address for upstream exceptions.
- `mem_r`  in  XLEN  ALU/CSR result.
- `mem_memadr`  in  XLEN  data-memory address of the load/store.
- `dmem_ack`  in  1  data-memory response valid, one-cycle pulse.
- `dmem_err`  in  1  bus error, qualified by `dmem_ack`.
- `dmem_q`  in  XLEN  raw read data, full naturally-aligned word.
- `wb_stall`  out  1  freeze all upstream stage registers.
- `wb_pc`  out  XLEN  committed PC.
- `wb_instr`  out  ILEN  committed instruction.
- `wb_bubble`  out  1  committed slot is empty.
- `wb_exception`  out  EXCEPTION_SIZE  committed exception vector.
- `wb_badaddr`  out  XLEN  mtval for the committed exception.
- `wb_we`  out  1  register-file write enable.
- `wb_dst`  out  5  register-file destination.
- `wb_r`  out  XLEN  register-file write data.

## Operation
- Decode from `mem_instr`:
  - `opcode=[6:0]`, `funct3=[14:12]`, `rd=[11:7]`.
  - LOAD is 7'b0000011; STORE is 7'b0100011.
- `memop = !mem_bubble && (LOAD||STORE) && ~|mem_exception && ~|wb_exception`.
- FSM:
  - States: IDLE, WAIT.
  - IDLE→WAIT when `memop && !dmem_ack`.
  - WAIT→IDLE on `dmem_ack`.
  - Any other condition holds the current state.
  - Reset goes to IDLE.
- `wb_stall = memop && !dmem_ack`. It is combinational and identical in IDLE and WAIT.
- When not stalled, every clock:
  - Register `wb_pc/instr/bubble/badaddr` from the MEM inputs.
  - If `|wb_exception` (currently committing an exception), squash the incoming instruction: `wb_bubble<=1`, `wb_exception<=0`, `wb_we<=0`.
  - Else if `|mem_exception`: `wb_exception<=mem_exception`, `wb_badaddr<=mem_pc_badaddr`, `wb_we<=0`.
  - Else if `memop && dmem_err`: set cause bit 5 (load access fault) or bit 7 (store access fault); `wb_badaddr<=mem_memadr`; `wb_we<=0`.
  - Else: `wb_exception<=0`, `wb_we <= !mem_bubble && rd!=0 && opcode not in {STORE, BRANCH 7'b1100011, MISC-MEM 7'b0001111, SYSTEM-with-rd=0}`.
- `wb_r`:
  - LOAD: select `dmem_q` lane from `mem_memadr[log2(XLEN/8)-1:0]`.
    - LB/LH: sign-extend.
    - LBU/LHU: zero-extend.
    - LW: sign-extend on XLEN=64, pass-through on XLEN=32.
    - LWU/LD: XLEN=64 only; zero-extend / pass-through.
  - Otherwise `wb_r<=mem_r`.
- `wb_dst<=rd` always, even when `wb_we=0`.
- Alignment is checked upstream. A misaligned address arrives with its exception already set, so it never causes a wait.

## Timing
- Reset values:
  - `wb_pc=PC_INIT`, `wb_instr=32'h00000013` (NOP), `wb_bubble=1`.
  - `wb_exception=0`, `wb_badaddr=0`, `wb_we=0`, `wb_dst=0`, `wb_r=0`.
  - FSM in IDLE.
- Latency:
  - Non-memory instruction: 1 cycle from MEM to `wb_*`.
  - Memory instruction: commits on the clock edge where `dmem_ack=1`. With an ack in the same cycle there is no stall; otherwise the stall lasts N cycles until the ack.
- `wb_stall` deasserts in the cycle `dmem_ack` is high, so upstream advances on that same edge.
- `wb_exception` is non-zero for exactly one cycle per exception. The following MEM instruction is squashed, matching MEM's own flush-on-`wb_exception`.
- `dmem_ack` in IDLE with no `memop` (stray ack) is ignored.
- `dmem_err` without `dmem_ack` is ignored.
- Reset mid-WAIT: the FSM returns to IDLE asynchronously and `wb_stall` drops once the MEM inputs reset to bubble.
- Registered outputs and FSM state are all asynchronously reset.

## Test plan
- Reset: assert `rstn=0` mid-WAIT. Required: `wb_stall=0` after MEM reset, `wb_pc='h200`, `wb_bubble=1`, `wb_we=0`, `wb_instr=32'h13`.
- ADDI x5 result `mem_r=32'h1234`, no memop. Required: next cycle `wb_we=1`, `wb_dst=5`, `wb_r=32'h1234`, `wb_stall=0` throughout.
- LB x6, `mem_memadr=32'h1003`, `dmem_q=32'h80FFFFFF`, ack after 3 cycles. Required: `wb_stall=1` for 3 cycles, then `wb_r=32'hFFFFFF80`, `wb_we=1`. Repeat with LBU: `wb_r=32'h00000080`.
- LHU x7, `mem_memadr=32'h2002`, `dmem_q=32'hBEEF0000`, ack in the same cycle. Required: no stall, `wb_r=32'h0000BEEF`.
- SW with `dmem_ack=1`, `dmem_err=1`, `mem_memadr=32'h40`. Required: `wb_exception` bit 7 set for one cycle, `wb_badaddr=32'h40`, `wb_we=0`. The next MEM instruction commits with `wb_bubble=1`.
- Write to x0 (ADDI x0) and a stray `dmem_ack` with a bubble in MEM. Required: `wb_we=0`, FSM stays IDLE, `wb_stall=0`.

Source files
------------

// File: rtl/riscv_wb_if.sv
// riscv_wb_if: MEM-to-WB pipeline, data-memory response and WB commit
// signals for the write-back stage.
//   slave  : used by riscv_wb. It receives mem_* and dmem_* and drives wb_*.
//   master : used by the environment or upstream. It drives mem_* and dmem_*
//            and observes wb_*.
interface riscv_wb_if #(
  parameter int XLEN           = 32,
  parameter int ILEN           = 32,
  parameter int EXCEPTION_SIZE = 16
);
  logic [XLEN-1:0]           mem_pc;
  logic [ILEN-1:0]           mem_instr;
  logic                      mem_bubble;
  logic [EXCEPTION_SIZE-1:0] mem_exception;
  logic [XLEN-1:0]           mem_pc_badaddr;
  logic [XLEN-1:0]           mem_r;
  logic [XLEN-1:0]           mem_memadr;
  logic                      dmem_ack;
  logic                      dmem_err;
  logic [XLEN-1:0]           dmem_q;
  logic                      wb_stall;
  logic [XLEN-1:0]           wb_pc;
  logic [ILEN-1:0]           wb_instr;
  logic                      wb_bubble;
  logic [EXCEPTION_SIZE-1:0] wb_exception;
  logic [XLEN-1:0]           wb_badaddr;
  logic                      wb_we;
  logic [4:0]                wb_dst;
  logic [XLEN-1:0]           wb_r;

  modport master (
    output mem_pc, mem_instr, mem_bubble, mem_exception, mem_pc_badaddr,
           mem_r, mem_memadr, dmem_ack, dmem_err, dmem_q,
    input  wb_stall, wb_pc, wb_instr, wb_bubble, wb_exception, wb_badaddr,
           wb_we, wb_dst, wb_r
  );

  modport slave (
    input  mem_pc, mem_instr, mem_bubble, mem_exception, mem_pc_badaddr,
           mem_r, mem_memadr, dmem_ack, dmem_err, dmem_q,
    output wb_stall, wb_pc, wb_instr, wb_bubble, wb_exception, wb_badaddr,
           wb_we, wb_dst, wb_r
  );
endinterface

// File: rtl/riscv_wb.sv
// riscv_wb: write-back stage of the RISC-V pipeline.
// It completes data-memory transactions and holds the upstream stages
// (wb_stall) until dmem_ack arrives. It aligns and extends load data and
// registers the register-file write port and the committed exception vector.
// Ports:
//   clk  : single clock, rising edge.
//   rstn : asynchronous active-low reset.
//   bus  : riscv_wb_if.slave. Inputs are mem_* and dmem_*. Outputs are
//          wb_stall (combinational) and the registered wb_* signals.
//
// state  | meaning
// IDLE   | no data-memory access outstanding
// WAIT   | load/store issued, waiting for dmem_ack
module riscv_wb #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] PC_INIT        = 'h200,
  parameter int              ILEN           = 32,
  parameter int              EXCEPTION_SIZE = 16
) (
  input logic       clk,
  input logic       rstn,
  riscv_wb_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int AW = $clog2(XLEN/8);

  localparam int CAUSE_LOAD_FAULT  = 5;
  localparam int CAUSE_STORE_FAULT = 7;

  logic [0:0]                state_q, state_d;
  logic [XLEN-1:0]           pc_q, badaddr_q, r_q;
  logic [ILEN-1:0]           instr_q;
  logic                      bubble_q, we_q;
  logic [EXCEPTION_SIZE-1:0] exc_q;
  logic [4:0]                dst_q;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic            is_load, is_store, memop, stall, no_write;
  logic [AW-1:0]   lane;
  logic [XLEN-1:0] shifted, ld_data;

  assign opcode   = bus.mem_instr[6:0];
  assign funct3   = bus.mem_instr[14:12];
  assign rd       = bus.mem_instr[11:7];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);

  // A committing exception blocks a new access. The following instruction
  // is about to be squashed, so it must not reach the memory.
  assign memop = !bus.mem_bubble && (is_load || is_store) &&
                 ~|bus.mem_exception && ~|exc_q;
  assign stall = memop && !bus.dmem_ack;

  assign no_write = is_store || (opcode == OP_BRANCH) || (opcode == OP_MISC) ||
                    ((opcode == OP_SYSTEM) && (rd == 5'd0));

  // dmem_q holds the full aligned word. Shift the addressed lane down to bit 0.
  assign lane    = bus.mem_memadr[AW-1:0];
  assign shifted = bus.dmem_q >> {lane, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (funct3)
      3'b000:  ld_data = XLEN'($signed(shifted[7:0]));
      3'b001:  ld_data = XLEN'($signed(shifted[15:0]));
      3'b010:  ld_data = XLEN'($signed(shifted[31:0]));
      3'b100:  ld_data = XLEN'(shifted[7:0]);
      3'b101:  ld_data = XLEN'(shifted[15:0]);
      3'b110:  ld_data = XLEN'(shifted[31:0]);
      default: ld_data = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (memop && !bus.dmem_ack) state_d = S_WAIT;
      S_WAIT:  if (bus.dmem_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q      <= PC_INIT;
      instr_q   <= ILEN'(32'h0000_0013);
      bubble_q  <= 1'b1;
      exc_q     <= '0;
      badaddr_q <= '0;
      we_q      <= 1'b0;
      dst_q     <= 5'd0;
      r_q       <= '0;
    end else if (!stall) begin
      pc_q      <= bus.mem_pc;
      instr_q   <= bus.mem_instr;
      bubble_q  <= bus.mem_bubble;
      badaddr_q <= bus.mem_pc_badaddr;
      dst_q     <= rd;
      r_q       <= is_load ? ld_data : bus.mem_r;
      if (|exc_q) begin
        bubble_q <= 1'b1;
        exc_q    <= '0;
        we_q     <= 1'b0;
      end else if (|bus.mem_exception) begin
        exc_q    <= bus.mem_exception;
        we_q     <= 1'b0;
      end else if (memop && bus.dmem_err) begin
        exc_q    <= '0;
        exc_q[is_load ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT] <= 1'b1;
        badaddr_q <= bus.mem_memadr;
        we_q     <= 1'b0;
      end else begin
        exc_q    <= '0;
        we_q     <= !bus.mem_bubble && (rd != 5'd0) && !no_write;
      end
    end
  end

  assign bus.wb_stall     = stall;
  assign bus.wb_pc        = pc_q;
  assign bus.wb_instr     = instr_q;
  assign bus.wb_bubble    = bubble_q;
  assign bus.wb_exception = exc_q;
  assign bus.wb_badaddr   = badaddr_q;
  assign bus.wb_we        = we_q;
  assign bus.wb_dst       = dst_q;
  assign bus.wb_r         = r_q;

endmodule
